wb_merge: RTL and testbench
===========================

Name: wb_merge

Overview:
- Writeback merge stage directly upstream of the register bank; sole driver of its single write port.
- Merges two sources:
  - in-order pipeline writeback, fixed latency, never stalled;
  - long-latency unit result (mult/div), valid/ready handshake through a small FIFO.
- Keeps a per-register pending scoreboard so the hazard unit can stall readers of registers awaiting a long-latency result.

Parameters:
- REG_FILE_DEPTH, 16, number of architectural registers; must equal the register bank depth.
- FIFO_DEPTH, 2, long-latency result buffer entries, power of 2, ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_wr_en  in  1  pipeline writeback request.
- pipe_wr_addr  in  REG_ADDR_W  pipeline destination register.
- pipe_wr_data  in  DATA_32_W  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept.
- lu_addr  in  REG_ADDR_W  long-latency destination register.
- lu_data  in  DATA_32_W  long-latency result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_addr  in  REG_ADDR_W  its destination register.
- reg_file_write  out  1  to register bank write enable.
- reg_file_wr_addr  out  REG_ADDR_W  to register bank.
- reg_file_wr_data  out  DATA_32_W  to register bank.
- pending_mask  out  REG_FILE_DEPTH  bit i = reg i awaits long-latency result.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- wb_err  out  1  sticky hazard-protocol violation.

Behaviour:
- Reset (rst=0, async): FIFO empty, fifo_count=0, reg_file_write=0, reg_file_wr_addr=0, reg_file_wr_data=0, pending_mask=0, wb_err=0.
- Outputs: reg_file_write/addr/data are registered. A selected write appears one cycle after selection; the bank captures it on the following edge.
- lu_ready = (fifo_count < FIFO_DEPTH); combinational from state only, never from lu_valid.
- Push = lu_valid & lu_ready.
- Selection, each cycle:
  - pipe_wr_en=1: pipeline wins; FIFO holds.
  - else if fifo_count>0: pop head.
  - else if push: bypass lu input directly; nothing is stored.
  - else: reg_file_write=0 next cycle.
- Push and pop in the same cycle: count unchanged, order preserved (FIFO order = acceptance order).
- Full FIFO with pop in the same cycle: lu_ready stays 0 that cycle. No same-cycle refill.
- Address 0: the selected entry is consumed (popped or bypassed), but reg_file_write=0. reg_file_wr_addr/data still update.
- Scoreboard:
  - issue_valid with issue_addr≠0 sets pending_mask[issue_addr] on the next edge.
  - Bit clears on the edge where the register bank captures the long-latency write (reg_file_write=1 and the registered write came from the lu path).
  - Track this with an internal out_from_lu flop.
  - Set and clear of the same bit in the same cycle: set wins.
- wb_err is set (sticky until reset) when any of:
  - issue_valid to an already-pending address;
  - pipe_wr_en to a pending address (WAW);
  - lu result selected for an address whose pending bit is 0.
- Starvation: a continuous pipe_wr_en stream blocks FIFO drain. This is legal; back-pressure reaches the unit via lu_ready.
- Reset mid-operation: all buffered results and pending bits are discarded immediately.

Decomposition:
- mips_pkg holds REG_ADDR_W and DATA_32_W (existing), plus a new typedef wb_entry_t {addr, data}.
- Sub-module wb_fifo: parameterised sync FIFO of wb_entry_t (push/pop/count/head).
- wb_merge contains selection, output register, scoreboard and error logic.

Test Plan:
- Reset, then pipe_wr_en=1, addr 5, data 0xDEADBEEF for one cycle → next cycle reg_file_write=1, addr=5, data=0xDEADBEEF; following cycle reg_file_write=0.
- issue_valid addr 7; 3 cycles later lu_valid addr 7, data 0x12345678, no pipe traffic → bypass: write of 0x12345678 to reg 7 appears next cycle; pending_mask[7]=1 until the capture edge, 0 after; fifo_count stays 0.
- Hold pipe_wr_en=1 for 4 cycles while lu pushes addr 3 (0xA) then addr 4 (0xB) → fifo_count=2, lu_ready=0, third lu_valid held. After pipe drops: writes reg 3 = 0xA then reg 4 = 0xB on consecutive cycles, then the held result.
- lu result addr 0 while fifo holds one entry → entry consumed, reg_file_write=0 that slot, fifo_count decrements; wb_err stays 0 (address 0 is never pending).
- issue_valid addr 9 twice with no intervening result → wb_err=1 and stays 1. Pipe write to pending reg 2 → wb_err=1.
- With fifo_count=2 and pending bits set, assert rst=0 mid-cycle → outputs zero immediately (before the next clock edge), pending_mask=0, lu_ready=1 after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Core-wide datapath widths and the writeback entry type carried through the merge FIFO.
// Shared by the writeback merge stage and its interface.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_32_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_32_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_merge_if.sv
// Signal bundle between the writeback merge stage and its neighbours (pipeline, long-latency unit,
// issue logic, register bank, hazard unit). slave = merge stage view, master = environment view.
interface wb_merge_if #(
    parameter int REG_FILE_DEPTH = 16,
    parameter int FIFO_DEPTH     = 2
) ();
    import mips_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                      pipe_wr_en;
    logic [REG_ADDR_W-1:0]     pipe_wr_addr;
    logic [DATA_32_W-1:0]      pipe_wr_data;
    logic                      lu_valid;
    logic                      lu_ready;
    logic [REG_ADDR_W-1:0]     lu_addr;
    logic [DATA_32_W-1:0]      lu_data;
    logic                      issue_valid;
    logic [REG_ADDR_W-1:0]     issue_addr;
    logic                      reg_file_write;
    logic [REG_ADDR_W-1:0]     reg_file_wr_addr;
    logic [DATA_32_W-1:0]      reg_file_wr_data;
    logic [REG_FILE_DEPTH-1:0] pending_mask;
    logic [CNT_W-1:0]          fifo_count;
    logic                      wb_err;

    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  lu_valid, lu_addr, lu_data,
        input  issue_valid, issue_addr,
        output lu_ready,
        output reg_file_write, reg_file_wr_addr, reg_file_wr_data,
        output pending_mask, fifo_count, wb_err
    );

    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output lu_valid, lu_addr, lu_data,
        output issue_valid, issue_addr,
        input  lu_ready,
        input  reg_file_write, reg_file_wr_addr, reg_file_wr_data,
        input  pending_mask, fifo_count, wb_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is valid whenever count is non-zero, one-cycle push-to-head.
// No internal backpressure: the caller must not push when full nor pop when empty.
module wb_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_dat,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_merge.sv
// Sole driver of the register-bank write port: merges pipeline writeback (priority) with buffered long-latency
// results, registered output one cycle after selection; lu_ready drops only when the FIFO is full.
module wb_merge
    import mips_pkg::*;
#(
    parameter int REG_FILE_DEPTH = 16,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic      clk,
    input  logic      rst,
    wb_merge_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                 lu_in;
    wb_entry_t                 fifo_head;
    wb_entry_t                 sel;
    logic [CNT_W-1:0]          fifo_count;
    logic                      push;
    logic                      pop;
    logic                      fifo_push;
    logic                      sel_vld;
    logic                      sel_lu;

    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_32_W-1:0]      wr_data_q, wr_data_d;
    logic                      out_from_lu_q, out_from_lu_d;
    logic [REG_FILE_DEPTH-1:0] pend_q, pend_d;
    logic                      err_q, err_d;

    // Register 0 never maps to a scoreboard bit, so it can never be pending.
    function automatic logic [REG_FILE_DEPTH-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        reg_onehot = '0;
        for (int i = 1; i < REG_FILE_DEPTH; i++) begin
            if (a == REG_ADDR_W'(i)) begin
                reg_onehot[i] = 1'b1;
            end
        end
    endfunction

    assign lu_in        = '{addr: bus.lu_addr, data: bus.lu_data};
    assign bus.lu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push         = bus.lu_valid & bus.lu_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (lu_in),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_comb begin
        sel       = lu_in;
        sel_vld   = 1'b0;
        sel_lu    = 1'b0;
        pop       = 1'b0;
        fifo_push = push;
        if (bus.pipe_wr_en) begin
            sel     = '{addr: bus.pipe_wr_addr, data: bus.pipe_wr_data};
            sel_vld = 1'b1;
        end else if (fifo_count != '0) begin
            sel     = fifo_head;
            sel_vld = 1'b1;
            sel_lu  = 1'b1;
            pop     = 1'b1;
        end else if (push) begin
            // Empty FIFO: hand the incoming result straight to the output register.
            sel_vld   = 1'b1;
            sel_lu    = 1'b1;
            fifo_push = 1'b0;
        end
    end

    always_comb begin
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        out_from_lu_d = 1'b0;
        if (sel_vld) begin
            wr_en_d       = (sel.addr != '0);
            wr_addr_d     = sel.addr;
            wr_data_d     = sel.data;
            out_from_lu_d = sel_lu;
        end

        // Clear on the bank capture edge; a same-cycle issue to the same register re-sets the bit.
        pend_d = pend_q;
        if (wr_en_q && out_from_lu_q) begin
            pend_d = pend_d & ~reg_onehot(wr_addr_q);
        end
        if (bus.issue_valid) begin
            pend_d = pend_d | reg_onehot(bus.issue_addr);
        end

        err_d = err_q;
        if (bus.issue_valid && |(pend_q & reg_onehot(bus.issue_addr))) begin
            err_d = 1'b1;
        end
        if (bus.pipe_wr_en && |(pend_q & reg_onehot(bus.pipe_wr_addr))) begin
            err_d = 1'b1;
        end
        if (sel_lu && (sel.addr != '0) && !(|(pend_q & reg_onehot(sel.addr)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            out_from_lu_q <= 1'b0;
            pend_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            out_from_lu_q <= out_from_lu_d;
            pend_q        <= pend_d;
            err_q         <= err_d;
        end
    end

    assign bus.reg_file_write   = wr_en_q;
    assign bus.reg_file_wr_addr = wr_addr_q;
    assign bus.reg_file_wr_data = wr_data_q;
    assign bus.pending_mask     = pend_q;
    assign bus.fifo_count       = fifo_count;
    assign bus.wb_err           = err_q;

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: a queue-based reference model predicts every cycle's write, occupancy, pending set
// and error flag; a monitor one time unit after each rising edge compares the DUT against those predictions.
module tb_wb_merge;
    import mips_pkg::*;

    localparam int RD = 16;
    localparam int FD = 2;

    typedef struct {
        wb_entry_t e;
        int        due;
    } lu_op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_merge_if #(.REG_FILE_DEPTH(RD), .FIFO_DEPTH(FD)) bus ();
    wb_merge #(.REG_FILE_DEPTH(RD), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    wb_entry_t     m_fifo[$];
    logic [RD-1:0] m_pend;
    logic          m_err;
    int            m_clr;
    bit            m_acc;

    wb_entry_t     exp_q[$];
    bit            e_wr;
    logic [RD-1:0] e_pend;
    int            e_count;
    logic          e_err;
    bit            chk_en = 1'b0;

    lu_op_t        lu_src[$];
    logic [RD-1:0] outstanding;
    bit            lu_hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_pend(input logic [REG_ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return (ai != 0) && (ai < RD) && (m_pend[ai] == 1'b1);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        lu_src.delete();
        m_pend      = '0;
        m_err       = 1'b0;
        m_clr       = -1;
        m_acc       = 1'b0;
        e_wr        = 1'b0;
        e_pend      = '0;
        e_count     = 0;
        e_err       = 1'b0;
        outstanding = '0;
        lu_hold     = 1'b0;
    endtask

    // Applies the merge rules to the inputs currently driven, as of the coming rising edge.
    task automatic model_step();
        wb_entry_t     sel;
        bit            have    = 1'b0;
        bit            from_lu = 1'b0;
        bit            push;
        logic [RD-1:0] np;
        int            ia;
        push  = bus.lu_valid && (m_fifo.size() < FD);
        m_acc = push;
        sel   = '{addr: bus.lu_addr, data: bus.lu_data};
        if (bus.pipe_wr_en) begin
            sel  = '{addr: bus.pipe_wr_addr, data: bus.pipe_wr_data};
            have = 1'b1;
            if (is_pend(bus.pipe_wr_addr)) m_err = 1'b1;
        end else if (m_fifo.size() > 0) begin
            sel     = m_fifo.pop_front();
            have    = 1'b1;
            from_lu = 1'b1;
        end else if (push) begin
            have    = 1'b1;
            from_lu = 1'b1;
            push    = 1'b0;
        end
        if (push) m_fifo.push_back('{addr: bus.lu_addr, data: bus.lu_data});
        if (from_lu && sel.addr != 0 && !is_pend(sel.addr)) m_err = 1'b1;
        if (bus.issue_valid && is_pend(bus.issue_addr)) m_err = 1'b1;
        ia = int'(bus.issue_addr);
        np = m_pend;
        if (m_clr >= 0) np[m_clr] = 1'b0;
        if (bus.issue_valid && ia != 0 && ia < RD) np[ia] = 1'b1;
        m_clr   = (from_lu && sel.addr != 0 && int'(sel.addr) < RD) ? int'(sel.addr) : -1;
        m_pend  = np;
        e_wr    = have && (sel.addr != 0);
        if (e_wr) exp_q.push_back(sel);
        e_pend  = m_pend;
        e_count = m_fifo.size();
        e_err   = m_err;
    endtask

    task automatic drive(input bit pe, input int pa, input logic [31:0] pd,
                         input bit lv, input int la, input logic [31:0] ld,
                         input bit iv, input int ia);
        bus.pipe_wr_en   = pe;
        bus.pipe_wr_addr = REG_ADDR_W'(pa);
        bus.pipe_wr_data = pd;
        bus.lu_valid     = lv;
        bus.lu_addr      = REG_ADDR_W'(la);
        bus.lu_data      = ld;
        bus.issue_valid  = iv;
        bus.issue_addr   = REG_ADDR_W'(ia);
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    endtask

    task automatic tick();
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst    = 1'b1;
        chk_en = 1'b1;
    endtask

    always @(posedge clk) begin
        wb_entry_t x;
        #1;
        if (chk_en) begin
            chk("lu_ready", 64'(bus.lu_ready), 64'(e_count < FD));
            chk("fifo_count", 64'(bus.fifo_count), 64'(e_count));
            chk("pending_mask", 64'(bus.pending_mask), 64'(e_pend));
            chk("wb_err", 64'(bus.wb_err), 64'(e_err));
            chk("reg_file_write", 64'(bus.reg_file_write), 64'(e_wr));
            if (e_wr && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("wr_addr", 64'(bus.reg_file_wr_addr), 64'(x.addr));
                chk("wr_data", 64'(bus.reg_file_wr_data), 64'(x.data));
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_write", 64'(bus.reg_file_write), 64'(0));
        chk("rst_addr", 64'(bus.reg_file_wr_addr), 64'(0));
        chk("rst_data", 64'(bus.reg_file_wr_data), 64'(0));
        chk("rst_pend", 64'(bus.pending_mask), 64'(0));
        chk("rst_count", 64'(bus.fifo_count), 64'(0));
        chk("rst_err", 64'(bus.wb_err), 64'(0));
        chk("rst_ready", 64'(bus.lu_ready), 64'(1));

        // Single pipeline write.
        drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 0); tick();
        chk("t1_write", 64'(bus.reg_file_write), 64'(1));
        chk("t1_addr", 64'(bus.reg_file_wr_addr), 64'(5));
        chk("t1_data", 64'(bus.reg_file_wr_data), 64'(32'hDEADBEEF));
        idle(); tick();
        chk("t1_after", 64'(bus.reg_file_write), 64'(0));

        // Issue then bypass of a long-latency result.
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 7); tick();
        idle(); tick(); tick();
        chk("t2_pend_set", 64'(bus.pending_mask[7]), 64'(1));
        drive(1'b0, 0, 32'h0, 1'b1, 7, 32'h12345678, 1'b0, 0); tick();
        chk("t2_write", 64'(bus.reg_file_write), 64'(1));
        chk("t2_addr", 64'(bus.reg_file_wr_addr), 64'(7));
        chk("t2_data", 64'(bus.reg_file_wr_data), 64'(32'h12345678));
        chk("t2_pend_hold", 64'(bus.pending_mask[7]), 64'(1));
        chk("t2_count", 64'(bus.fifo_count), 64'(0));
        idle(); tick();
        chk("t2_pend_clr", 64'(bus.pending_mask[7]), 64'(0));

        // Pipeline starves the FIFO until it fills; drain in acceptance order, no same-cycle refill.
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 3); tick();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 4); tick();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 5); tick();
        drive(1'b1, 1, $urandom, 1'b1, 3, 32'hA, 1'b0, 0); tick();
        drive(1'b1, 2, $urandom, 1'b1, 4, 32'hB, 1'b0, 0); tick();
        chk("t3_full_count", 64'(bus.fifo_count), 64'(2));
        chk("t3_full_ready", 64'(bus.lu_ready), 64'(0));
        drive(1'b1, 1, $urandom, 1'b1, 5, 32'hC, 1'b0, 0); tick();
        drive(1'b1, 2, $urandom, 1'b1, 5, 32'hC, 1'b0, 0); tick();
        chk("t3_held_ready", 64'(bus.lu_ready), 64'(0));
        drive(1'b0, 0, 32'h0, 1'b1, 5, 32'hC, 1'b0, 0); tick();
        chk("t3_w1_addr", 64'(bus.reg_file_wr_addr), 64'(3));
        chk("t3_w1_data", 64'(bus.reg_file_wr_data), 64'(32'hA));
        chk("t3_w1_count", 64'(bus.fifo_count), 64'(1));
        drive(1'b0, 0, 32'h0, 1'b1, 5, 32'hC, 1'b0, 0); tick();
        chk("t3_w2_addr", 64'(bus.reg_file_wr_addr), 64'(4));
        chk("t3_w2_data", 64'(bus.reg_file_wr_data), 64'(32'hB));
        idle(); tick();
        chk("t3_w3_addr", 64'(bus.reg_file_wr_addr), 64'(5));
        chk("t3_w3_data", 64'(bus.reg_file_wr_data), 64'(32'hC));
        chk("t3_w3_count", 64'(bus.fifo_count), 64'(0));
        idle(); tick();

        // Long-latency result to register 0 is consumed without a write.
        drive(1'b1, 6, $urandom, 1'b1, 0, 32'h55, 1'b0, 0); tick();
        chk("t4_count1", 64'(bus.fifo_count), 64'(1));
        idle(); tick();
        chk("t4_write", 64'(bus.reg_file_write), 64'(0));
        chk("t4_addr", 64'(bus.reg_file_wr_addr), 64'(0));
        chk("t4_data", 64'(bus.reg_file_wr_data), 64'(32'h55));
        chk("t4_count0", 64'(bus.fifo_count), 64'(0));
        chk("t4_err", 64'(bus.wb_err), 64'(0));

        // Randomised protocol-respecting traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit            iv;
            bit            pe;
            int            ia;
            int            pa;
            logic [RD-1:0] avoid;
            lu_op_t        op;
            wb_entry_t     lu;
            iv    = 1'b0;
            ia    = 0;
            avoid = outstanding | m_pend;
            if ($urandom_range(0, 99) < 25) begin
                ia = int'($urandom_range(0, RD - 1));
                if (ia == 0 || !avoid[ia]) begin
                    iv        = 1'b1;
                    op.e.addr = REG_ADDR_W'(ia);
                    op.e.data = $urandom;
                    op.due    = cyc + 1 + int'($urandom_range(0, 4));
                    lu_src.push_back(op);
                    if (ia != 0) outstanding[ia] = 1'b1;
                end
            end
            avoid = outstanding | m_pend;
            pe    = ($urandom_range(0, 99) < 40);
            pa    = int'($urandom_range(0, RD - 1));
            if (pa != 0 && avoid[pa]) pa = 0;
            if (!lu_hold && lu_src.size() > 0 && lu_src[0].due <= cyc && $urandom_range(0, 99) < 70)
                lu_hold = 1'b1;
            lu = lu_hold ? lu_src[0].e : '0;
            drive(pe, pa, $urandom, lu_hold, int'(lu.addr), lu.data, iv, ia);
            tick();
            if (m_acc) begin
                if (lu.addr != 0) outstanding[int'(lu.addr)] = 1'b0;
                void'(lu_src.pop_front());
                lu_hold = 1'b0;
            end
        end
        idle();
        repeat (6) tick();
        chk("rand_no_err", 64'(bus.wb_err), 64'(0));

        // Asynchronous reset with a full FIFO and pending registers.
        do_reset();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 7); tick();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 8); tick();
        drive(1'b1, 1, $urandom, 1'b1, 7, 32'h77, 1'b0, 0); tick();
        drive(1'b1, 2, 32'h2222, 1'b1, 8, 32'h88, 1'b0, 0); tick();
        chk("rm_count", 64'(bus.fifo_count), 64'(2));
        chk("rm_pend", 64'(bus.pending_mask), 64'(16'h0180));
        idle();
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("rm_write", 64'(bus.reg_file_write), 64'(0));
        chk("rm_addr", 64'(bus.reg_file_wr_addr), 64'(0));
        chk("rm_data", 64'(bus.reg_file_wr_data), 64'(0));
        chk("rm_pend0", 64'(bus.pending_mask), 64'(0));
        chk("rm_count0", 64'(bus.fifo_count), 64'(0));
        chk("rm_err", 64'(bus.wb_err), 64'(0));
        @(negedge clk);
        model_reset();
        rst    = 1'b1;
        chk_en = 1'b1;
        chk("rm_ready", 64'(bus.lu_ready), 64'(1));
        tick();
        tick();

        // Protocol violations raise a sticky error.
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9); tick();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9); tick();
        chk("e1_err", 64'(bus.wb_err), 64'(1));
        idle();
        repeat (3) tick();
        chk("e1_sticky", 64'(bus.wb_err), 64'(1));
        do_reset();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 2); tick();
        idle(); tick();
        chk("e2_before", 64'(bus.wb_err), 64'(0));
        drive(1'b1, 2, 32'h22, 1'b0, 0, 32'h0, 1'b0, 0); tick();
        chk("e2_waw", 64'(bus.wb_err), 64'(1));
        idle(); tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
